// File: rtl/ex_hazard_pkg.sv
// ============================================================================
// Module   : ex_hazard_pkg
// Purpose  : Shared FSM state, hazard-cause encoding and constants used by
//            the EX-stage pipeline sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ex_hazard_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // Listed in decreasing priority; only one cause drives the outputs per cycle.
    typedef enum logic [1:0] {
        NONE    = 2'd0,
        BRANCH  = 2'd1,
        MULDIV  = 2'd2,
        LOADUSE = 2'd3
    } cause_e;

    localparam int REG_ZERO = 0;

endpackage

`default_nettype wire

// File: rtl/load_use_detect.sv
// ============================================================================
// Module   : load_use_detect
// Purpose  : Combinational load-use compare of the ID/EX load destination
//            against the IF/ID source registers. Register 0 never matches.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_use_detect
    import ex_hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  i_idex_memread,
    input  logic [REG_ADDR_W-1:0] i_idex_rt,
    input  logic [REG_ADDR_W-1:0] i_ifid_rs,
    input  logic [REG_ADDR_W-1:0] i_ifid_rt,
    input  logic                  i_ifid_uses_rt,
    output logic                  o_hazard
);

    logic w_rt_nonzero;
    logic w_rs_match;
    logic w_rt_match;

    assign w_rt_nonzero = (i_idex_rt != REG_ADDR_W'(REG_ZERO));
    assign w_rs_match   = (i_idex_rt == i_ifid_rs);
    assign w_rt_match   = i_ifid_uses_rt & (i_idex_rt == i_ifid_rt);
    assign o_hazard     = i_idex_memread & w_rt_nonzero & (w_rs_match | w_rt_match);

endmodule

`default_nettype wire

// File: rtl/ex_hazard_ctrl.sv
// ============================================================================
// Module   : ex_hazard_ctrl
// Purpose  : MIPS EX-stage sequencer: load-use stalls, taken-branch flushes
//            and multi-cycle mult/div front-end freeze.
//            Optional macro EX_HAZARD_PERF_EN adds 32-bit perf counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_hazard_ctrl
    import ex_hazard_pkg::*;
#(
    parameter int MULDIV_CYCLES = 32,
    parameter int REG_ADDR_W    = 5,
    parameter int CNT_W         = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  idex_memread,
    input  logic [REG_ADDR_W-1:0] idex_rt,
    input  logic [REG_ADDR_W-1:0] ifid_rs,
    input  logic [REG_ADDR_W-1:0] ifid_rt,
    input  logic                  ifid_uses_rt,
    input  logic                  idex_muldiv,
    input  logic                  exmem_branch,
    input  logic                  exmem_zero,
    output logic                  pc_write,
    output logic                  ifid_write,
    output logic                  ifid_flush,
    output logic                  idex_write,
    output logic                  idex_bubble,
    output logic                  exmem_bubble,
    output logic                  pc_src_branch,
    output logic                  muldiv_busy,
    output logic                  muldiv_done
`ifdef EX_HAZARD_PERF_EN
    ,
    output logic [31:0]           stall_cycles,
    output logic [31:0]           flush_count,
    output logic [31:0]           muldiv_count
`endif
);

    state_e           r_state_q, w_state_d;
    logic [CNT_W-1:0] r_cnt_q,   w_cnt_d;
    cause_e           w_cause;
    logic             w_taken;
    logic             w_load_use;

    load_use_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_load_use_detect (
        .i_idex_memread (idex_memread),
        .i_idex_rt      (idex_rt),
        .i_ifid_rs      (ifid_rs),
        .i_ifid_rt      (ifid_rt),
        .i_ifid_uses_rt (ifid_uses_rt),
        .o_hazard       (w_load_use)
    );

    assign w_taken = exmem_branch & exmem_zero;

    always_comb begin
        w_state_d   = r_state_q;
        w_cnt_d     = r_cnt_q;
        w_cause     = NONE;
        muldiv_done = 1'b0;
        if (!rst) begin
            case (r_state_q)
                IDLE: begin
                    if (w_taken) begin
                        w_cause = BRANCH;
                    end else if (idex_muldiv) begin
                        // Start cycle plus BUSY cycles add up to MULDIV_CYCLES-1 frozen cycles.
                        w_cause   = MULDIV;
                        w_cnt_d   = CNT_W'(MULDIV_CYCLES - 2);
                        w_state_d = (MULDIV_CYCLES == 2) ? DONE : BUSY;
                    end else if (w_load_use) begin
                        w_cause = LOADUSE;
                    end
                end
                BUSY: begin
                    w_cause = MULDIV;
                    w_cnt_d = r_cnt_q - CNT_W'(1);
                    if (r_cnt_q <= CNT_W'(1)) begin
                        w_state_d = DONE;
                    end
                end
                DONE: begin
                    muldiv_done = 1'b1;
                    w_state_d   = IDLE;
                    if (w_load_use) begin
                        w_cause = LOADUSE;
                    end
                end
                default: begin
                    w_state_d = IDLE;
                end
            endcase
        end
    end

    always_comb begin
        pc_write      = 1'b1;
        ifid_write    = 1'b1;
        ifid_flush    = 1'b0;
        idex_write    = 1'b1;
        idex_bubble   = 1'b0;
        exmem_bubble  = 1'b0;
        pc_src_branch = 1'b0;
        muldiv_busy   = 1'b0;
        case (w_cause)
            BRANCH: begin
                pc_src_branch = 1'b1;
                ifid_flush    = 1'b1;
                idex_bubble   = 1'b1;
                exmem_bubble  = 1'b1;
            end
            MULDIV: begin
                pc_write     = 1'b0;
                ifid_write   = 1'b0;
                idex_write   = 1'b0;
                exmem_bubble = 1'b1;
                muldiv_busy  = 1'b1;
            end
            LOADUSE: begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_bubble = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= IDLE;
            r_cnt_q   <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_cnt_q   <= w_cnt_d;
        end
    end

`ifdef EX_HAZARD_PERF_EN
    logic [31:0] r_stall_cycles_q, w_stall_cycles_d;
    logic [31:0] r_flush_count_q,  w_flush_count_d;
    logic [31:0] r_muldiv_count_q, w_muldiv_count_d;

    always_comb begin
        w_stall_cycles_d = r_stall_cycles_q;
        w_flush_count_d  = r_flush_count_q;
        w_muldiv_count_d = r_muldiv_count_q;
        if (!pc_write) begin
            w_stall_cycles_d = r_stall_cycles_q + 32'd1;
        end
        if (w_cause == BRANCH) begin
            w_flush_count_d = r_flush_count_q + 32'd1;
        end
        if (muldiv_done) begin
            w_muldiv_count_d = r_muldiv_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles_q <= '0;
            r_flush_count_q  <= '0;
            r_muldiv_count_q <= '0;
        end else begin
            r_stall_cycles_q <= w_stall_cycles_d;
            r_flush_count_q  <= w_flush_count_d;
            r_muldiv_count_q <= w_muldiv_count_d;
        end
    end

    assign stall_cycles = r_stall_cycles_q;
    assign flush_count  = r_flush_count_q;
    assign muldiv_count = r_muldiv_count_q;
`endif

endmodule

`default_nettype wire
